// File: rtl/uart_rx_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_cmd_sequencer_pkg                                        |
// | Brief   : Opcodes, state encoding and operand addresses shared by the      |
// |           command sequencer, the TX side and the system bench.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package uart_rx_cmd_sequencer_pkg;

  // Frame opcodes, only recognised while the sequencer is idle
  localparam logic [7:0] c_OP_WR  = 8'hAA;
  localparam logic [7:0] c_OP_RD  = 8'hBB;
  localparam logic [7:0] c_OP_ALU = 8'hCC;
  localparam logic [7:0] c_OP_NOP = 8'hDD;

  // Reg-file locations that hold the ALU operands
  localparam int c_OPA_ADDR = 0;
  localparam int c_OPB_ADDR = 1;

  // State encoding
  localparam int c_ST_WD = 4;
  typedef logic [c_ST_WD-1:0] state_t;

  localparam state_t c_ST_IDLE     = 4'd0;
  localparam state_t c_ST_WR_ADDR  = 4'd1;
  localparam state_t c_ST_WR_DATA  = 4'd2;
  localparam state_t c_ST_RD_ADDR  = 4'd3;
  localparam state_t c_ST_RD_WAIT  = 4'd4;
  localparam state_t c_ST_OPA      = 4'd5;
  localparam state_t c_ST_OPB      = 4'd6;
  localparam state_t c_ST_ALU_FUN  = 4'd7;
  localparam state_t c_ST_ALU_WAIT = 4'd8;
  localparam state_t c_ST_TX_B0    = 4'd9;
  localparam state_t c_ST_TX_B1    = 4'd10;

  // Decoded class of a byte received while idle
  typedef enum logic [2:0] {
    CMD_WR  = 3'd0,
    CMD_RD  = 3'd1,
    CMD_ALU = 3'd2,
    CMD_NOP = 3'd3,
    CMD_BAD = 3'd4
  } cmd_t;

  function automatic cmd_t f_decode_cmd(input logic [7:0] b);
    cmd_t c;
    case (b)
      c_OP_WR:  c = CMD_WR;
      c_OP_RD:  c = CMD_RD;
      c_OP_ALU: c = CMD_ALU;
      c_OP_NOP: c = CMD_NOP;
      default:  c = CMD_BAD;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_cmd_sequencer_if                                         |
// | Brief   : Byte-stream, reg-file, ALU and TX-FIFO signals of the command    |
// |           sequencer. master = sequencer side, slave = system side.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_rx_cmd_sequencer_if #(
  parameter int DATA_WD    = 8,
  parameter int ADDR_WD    = 4,
  parameter int ALU_OUT_WD = 16,
  parameter int FUN_WD     = 4
);

  logic [DATA_WD-1:0]    RX_P_DATA;
  logic                  RX_D_VLD;
  logic [ADDR_WD-1:0]    RF_ADDR;
  logic                  RF_WR_EN;
  logic [DATA_WD-1:0]    RF_WR_DATA;
  logic                  RF_RD_EN;
  logic [DATA_WD-1:0]    RF_RD_DATA;
  logic                  RF_RD_VLD;
  logic                  ALU_EN;
  logic [FUN_WD-1:0]     ALU_FUN;
  logic [ALU_OUT_WD-1:0] ALU_OUT;
  logic                  ALU_OUT_VLD;
  logic                  CLK_GATE_EN;
  logic [DATA_WD-1:0]    TX_WR_DATA;
  logic                  TX_WR_INC;
  logic                  TX_FULL;
  logic                  BUSY;
  logic                  CMD_DROP;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_FULL,
    output RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_WR_DATA, TX_WR_INC, BUSY, CMD_DROP
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_FULL,
    input  RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_WR_DATA, TX_WR_INC, BUSY, CMD_DROP
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_cmd_sequencer                                            |
// | Brief   : Decodes 1-4 byte UART command frames, sequences reg-file writes/ |
// |           reads and ALU operations, and pushes response bytes to TX FIFO.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_cmd_sequencer
  import uart_rx_cmd_sequencer_pkg::*;
#(
  parameter int DATA_WD    = 8,
  parameter int ADDR_WD    = 4,
  parameter int ALU_OUT_WD = 16,
  parameter int FUN_WD     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_rx_cmd_sequencer_if.master  bus
);

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WD-1:0]    r_addr,    w_addr_nxt;
  logic [DATA_WD-1:0]    r_wr_data, w_wr_data_nxt;
  logic [FUN_WD-1:0]     r_fun,     w_fun_nxt;
  logic [DATA_WD-1:0]    r_tx_data, w_tx_data_nxt;
  logic [ALU_OUT_WD-1:0] r_result,  w_result_nxt;
  logic                  r_single,  w_single_nxt;
  logic                  r_cge,     w_cge_nxt;
  logic                  r_wr_en,   w_wr_en_nxt;
  logic                  r_rd_en,   w_rd_en_nxt;
  logic                  r_alu_en,  w_alu_en_nxt;
  logic                  r_tx_inc,  w_tx_inc_nxt;
  logic                  r_drop,    w_drop_nxt;

  logic                  w_rx;
  cmd_t                  w_cmd;
  logic                  w_push_ok;

  assign w_rx  = bus.RX_D_VLD;
  assign w_cmd = f_decode_cmd(bus.RX_P_DATA[7:0]);
  // A push is never issued back-to-back, so the FIFO full flag always reflects
  // the previous push before the next byte is committed.
  assign w_push_ok = !bus.TX_FULL && !r_tx_inc;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: bytes advance the frame, valids leave the wait states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_rx) begin
          case (w_cmd)
            CMD_WR:  w_state_nxt = c_ST_WR_ADDR;
            CMD_RD:  w_state_nxt = c_ST_RD_ADDR;
            CMD_ALU: w_state_nxt = c_ST_OPA;
            CMD_NOP: w_state_nxt = c_ST_ALU_FUN;
            default: w_state_nxt = c_ST_IDLE;
          endcase
        end
      end
      c_ST_WR_ADDR:  if (w_rx) w_state_nxt = c_ST_WR_DATA;
      c_ST_WR_DATA:  if (w_rx) w_state_nxt = c_ST_IDLE;
      c_ST_RD_ADDR:  if (w_rx) w_state_nxt = c_ST_RD_WAIT;
      c_ST_RD_WAIT:  if (bus.RF_RD_VLD) w_state_nxt = c_ST_TX_B0;
      c_ST_OPA:      if (w_rx) w_state_nxt = c_ST_OPB;
      c_ST_OPB:      if (w_rx) w_state_nxt = c_ST_ALU_FUN;
      c_ST_ALU_FUN:  if (w_rx) w_state_nxt = c_ST_ALU_WAIT;
      c_ST_ALU_WAIT: if (bus.ALU_OUT_VLD) w_state_nxt = c_ST_TX_B0;
      c_ST_TX_B0:    if (w_push_ok) w_state_nxt = r_single ? c_ST_IDLE : c_ST_TX_B1;
      c_ST_TX_B1:    if (w_push_ok) w_state_nxt = c_ST_IDLE;
      default:       w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode: strobes for the following cycle and capture-register updates
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_alu_en_nxt  = 1'b0;
    w_tx_inc_nxt  = 1'b0;
    w_drop_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_fun_nxt     = r_fun;
    w_tx_data_nxt = r_tx_data;
    w_result_nxt  = r_result;
    w_single_nxt  = r_single;
    w_cge_nxt     = r_cge;
    case (r_state)
      c_ST_IDLE: begin
        if (w_rx && (w_cmd == CMD_BAD)) w_drop_nxt = 1'b1;
      end
      c_ST_WR_ADDR: begin
        if (w_rx) w_addr_nxt = bus.RX_P_DATA[ADDR_WD-1:0];
      end
      c_ST_WR_DATA: begin
        if (w_rx) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = bus.RX_P_DATA;
        end
      end
      c_ST_RD_ADDR: begin
        if (w_rx) begin
          w_addr_nxt  = bus.RX_P_DATA[ADDR_WD-1:0];
          w_rd_en_nxt = 1'b1;
        end
      end
      c_ST_RD_WAIT: begin
        w_drop_nxt = w_rx;
        if (bus.RF_RD_VLD) begin
          w_result_nxt = {{(ALU_OUT_WD-DATA_WD){1'b0}}, bus.RF_RD_DATA};
          w_single_nxt = 1'b1;
        end
      end
      c_ST_OPA, c_ST_OPB: begin
        if (w_rx) begin
          w_addr_nxt    = (r_state == c_ST_OPA) ? ADDR_WD'(c_OPA_ADDR) : ADDR_WD'(c_OPB_ADDR);
          w_wr_data_nxt = bus.RX_P_DATA;
          w_wr_en_nxt   = 1'b1;
        end
      end
      c_ST_ALU_FUN: begin
        if (w_rx) begin
          w_alu_en_nxt = 1'b1;
          w_fun_nxt    = bus.RX_P_DATA[FUN_WD-1:0];
          w_cge_nxt    = 1'b1;
        end
      end
      c_ST_ALU_WAIT: begin
        w_drop_nxt = w_rx;
        if (bus.ALU_OUT_VLD) begin
          w_result_nxt = bus.ALU_OUT;
          w_single_nxt = 1'b0;
        end
      end
      c_ST_TX_B0: begin
        w_drop_nxt = w_rx;
        if (w_push_ok) begin
          w_tx_inc_nxt  = 1'b1;
          w_tx_data_nxt = r_result[DATA_WD-1:0];
          if (r_single) w_cge_nxt = 1'b0;
        end
      end
      c_ST_TX_B1: begin
        w_drop_nxt = w_rx;
        if (w_push_ok) begin
          w_tx_inc_nxt  = 1'b1;
          w_tx_data_nxt = r_result[2*DATA_WD-1:DATA_WD];
          w_cge_nxt     = 1'b0;
        end
      end
      default: begin
        w_drop_nxt = 1'b0;
      end
    endcase
  end

  // Output and capture registers; reset abandons any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr    <= '0;
      r_wr_data <= '0;
      r_fun     <= '0;
      r_tx_data <= '0;
      r_result  <= '0;
      r_single  <= 1'b0;
      r_cge     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_tx_inc  <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_fun     <= w_fun_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_result  <= w_result_nxt;
      r_single  <= w_single_nxt;
      r_cge     <= w_cge_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_alu_en  <= w_alu_en_nxt;
      r_tx_inc  <= w_tx_inc_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign bus.RF_ADDR     = r_addr;
  assign bus.RF_WR_EN    = r_wr_en;
  assign bus.RF_WR_DATA  = r_wr_data;
  assign bus.RF_RD_EN    = r_rd_en;
  assign bus.ALU_EN      = r_alu_en;
  assign bus.ALU_FUN     = r_fun;
  assign bus.CLK_GATE_EN = r_cge;
  assign bus.TX_WR_DATA  = r_tx_data;
  assign bus.TX_WR_INC   = r_tx_inc;
  assign bus.BUSY        = (r_state != c_ST_IDLE);
  assign bus.CMD_DROP    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_cmd_sequencer                                         |
// | Brief   : Self-checking bench: directed and random command frames against  |
// |           a frame-level model, with reg-file / ALU / TX-FIFO responders.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_rx_cmd_sequencer;

  logic CLK_TB = 1'b0;
  logic rst;
  always #5 CLK_TB = ~CLK_TB;

  uart_rx_cmd_sequencer_if bus ();

  uart_rx_cmd_sequencer dut (
    .CLK (CLK_TB),
    .RST (rst),
    .bus (bus.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Environment configuration (written by the stimulus only)
  int rd_lat_cfg  = 1;
  int alu_lat_cfg = 1;
  int full_until  = 0;

  // Observations (written by the monitor only)
  logic [11:0] obs_wr[$];
  logic [3:0]  obs_rd[$];
  logic [3:0]  obs_fun[$];
  logic [7:0]  obs_tx[$];
  int          obs_drop    = 0;
  int          overlap_err = 0;
  int          full_err    = 0;
  int          cge_err     = 0;

  // Environment reg file and responder state
  logic [7:0]  env_rf[16];
  int          rd_cnt  = 0;
  int          alu_cnt = 0;
  logic [3:0]  rd_addr_l;
  logic [3:0]  alu_fun_l;

  // Frame-level reference model
  logic [7:0]  model_rf[16];
  logic [7:0]  frm[$];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_fun[$];
  logic [7:0]  exp_tx[$];
  int          exp_drop;
  int          inject;
  int          stall;

  // ALU behaviour of the surrounding system
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] f);
    logic [15:0] r;
    case (f[1:0])
      2'd0:    r = 16'(a) + 16'(b);
      2'd1:    r = 16'(a) - 16'(b);
      2'd2:    r = 16'(a) * 16'(b);
      default: r = {a, b};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Monitor and responders, evaluated mid-cycle
  always @(negedge CLK_TB) begin : p_mon
    int s;
    cyc = cyc + 1;
    s = int'(bus.RF_WR_EN) + int'(bus.RF_RD_EN) + int'(bus.ALU_EN) + int'(bus.TX_WR_INC);
    if (s > 1) overlap_err++;
    if (bus.TX_WR_INC === 1'b1 && bus.TX_FULL === 1'b1) full_err++;
    if (bus.ALU_EN === 1'b1 && bus.CLK_GATE_EN !== 1'b1) cge_err++;
    if (bus.BUSY === 1'b0 && bus.CLK_GATE_EN === 1'b1) cge_err++;
    if (bus.RF_WR_EN === 1'b1) begin
      obs_wr.push_back({bus.RF_ADDR, bus.RF_WR_DATA});
      env_rf[bus.RF_ADDR] = bus.RF_WR_DATA;
    end
    if (bus.CMD_DROP === 1'b1) obs_drop++;
    if (bus.TX_WR_INC === 1'b1) obs_tx.push_back(bus.TX_WR_DATA);
    bus.RF_RD_VLD = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus.RF_RD_VLD  = 1'b1;
        bus.RF_RD_DATA = env_rf[rd_addr_l];
      end
    end
    if (bus.RF_RD_EN === 1'b1) begin
      obs_rd.push_back(bus.RF_ADDR);
      rd_addr_l = bus.RF_ADDR;
      rd_cnt    = rd_lat_cfg;
    end
    bus.ALU_OUT_VLD = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        bus.ALU_OUT_VLD = 1'b1;
        bus.ALU_OUT     = alu_f(env_rf[0], env_rf[1], alu_fun_l);
      end
    end
    if (bus.ALU_EN === 1'b1) begin
      obs_fun.push_back(bus.ALU_FUN);
      alu_fun_l = bus.ALU_FUN;
      alu_cnt   = alu_lat_cfg;
    end
    if (rst === 1'b1) begin
      rd_cnt  = 0;
      alu_cnt = 0;
    end
    bus.TX_FULL = (cyc < full_until);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK_TB); #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK_TB); #1;
    bus.RX_D_VLD  = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge CLK_TB);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK_TB);
    while (bus.BUSY !== 1'b0 && n < 400) begin
      @(negedge CLK_TB);
      n++;
    end
    check("busy_end", 32'(bus.BUSY), 32'd0);
    repeat (3) @(negedge CLK_TB);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(bus.BUSY),        32'd0);
    check({tag, "_wr"},    32'(bus.RF_WR_EN),    32'd0);
    check({tag, "_rd"},    32'(bus.RF_RD_EN),    32'd0);
    check({tag, "_alu"},   32'(bus.ALU_EN),      32'd0);
    check({tag, "_inc"},   32'(bus.TX_WR_INC),   32'd0);
    check({tag, "_drop"},  32'(bus.CMD_DROP),    32'd0);
    check({tag, "_cge"},   32'(bus.CLK_GATE_EN), 32'd0);
    check({tag, "_addr"},  32'(bus.RF_ADDR),     32'd0);
    check({tag, "_fun"},   32'(bus.ALU_FUN),     32'd0);
    check({tag, "_wdat"},  32'(bus.RF_WR_DATA),  32'd0);
    check({tag, "_tdat"},  32'(bus.TX_WR_DATA),  32'd0);
  endtask

  // Run the frame in frm: derive expectations, drive bytes, compare activity
  task automatic run_frame();
    int b_wr   = obs_wr.size();
    int b_rd   = obs_rd.size();
    int b_fun  = obs_fun.size();
    int b_tx   = obs_tx.size();
    int b_drop = obs_drop;
    logic [3:0]  a;
    logic [15:0] r;
    logic        has_wait;
    exp_wr.delete(); exp_rd.delete(); exp_fun.delete(); exp_tx.delete();
    exp_drop = 0;
    has_wait = 1'b1;
    case (frm[0])
      8'hAA: begin
        a = frm[1][3:0];
        exp_wr.push_back({a, frm[2]});
        model_rf[a] = frm[2];
        has_wait = 1'b0;
      end
      8'hBB: begin
        a = frm[1][3:0];
        exp_rd.push_back(a);
        exp_tx.push_back(model_rf[a]);
      end
      8'hCC: begin
        model_rf[0] = frm[1];
        model_rf[1] = frm[2];
        exp_wr.push_back({4'h0, frm[1]});
        exp_wr.push_back({4'h1, frm[2]});
        exp_fun.push_back(frm[3][3:0]);
        r = alu_f(model_rf[0], model_rf[1], frm[3][3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end
      8'hDD: begin
        exp_fun.push_back(frm[1][3:0]);
        r = alu_f(model_rf[0], model_rf[1], frm[1][3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end
      default: begin
        exp_drop = 1;
        has_wait = 1'b0;
      end
    endcase
    foreach (frm[i]) begin
      if (i == frm.size() - 1 && stall > 0) full_until = cyc + stall + 8;
      send_byte(frm[i]);
    end
    if (inject != 0 && has_wait) begin
      repeat (2) @(posedge CLK_TB);
      send_byte(8'($urandom));
      exp_drop++;
    end
    wait_idle();
    check("wr_n",   32'(obs_wr.size() - b_wr),   32'(exp_wr.size()));
    check("rd_n",   32'(obs_rd.size() - b_rd),   32'(exp_rd.size()));
    check("fun_n",  32'(obs_fun.size() - b_fun), 32'(exp_fun.size()));
    check("tx_n",   32'(obs_tx.size() - b_tx),   32'(exp_tx.size()));
    check("drop_n", 32'(obs_drop - b_drop),      32'(exp_drop));
    foreach (exp_wr[i])  if (b_wr + i < obs_wr.size())   check("wr",  32'(obs_wr[b_wr + i]),   32'(exp_wr[i]));
    foreach (exp_rd[i])  if (b_rd + i < obs_rd.size())   check("rd",  32'(obs_rd[b_rd + i]),   32'(exp_rd[i]));
    foreach (exp_fun[i]) if (b_fun + i < obs_fun.size()) check("fun", 32'(obs_fun[b_fun + i]), 32'(exp_fun[i]));
    foreach (exp_tx[i])  if (b_tx + i < obs_tx.size())   check("tx",  32'(obs_tx[b_tx + i]),   32'(exp_tx[i]));
    check("overlap", 32'(overlap_err), 32'd0);
    check("push_while_full", 32'(full_err), 32'd0);
    check("clk_gate", 32'(cge_err), 32'd0);
    inject = 0;
    stall  = 0;
  endtask

  initial begin : p_stim
    int b_wr;
    int b_drop;
    int t;
    logic [7:0] bad;
    rst           = 1'b1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = '0;
    inject        = 0;
    stall         = 0;
    repeat (3) @(posedge CLK_TB);
    @(negedge CLK_TB);
    check_idle("reset");
    @(posedge CLK_TB); #1;
    rst = 1'b0;

    // Fill every reg-file location (upper address bits randomised)
    for (int i = 0; i < 16; i++) begin
      frm = {8'hAA, 8'({4'($urandom), 4'(i)}), 8'($urandom)};
      run_frame();
    end

    // Directed frames
    frm = {8'hAA, 8'h05, 8'h3C};               run_frame();
    rd_lat_cfg = 3;
    frm = {8'hBB, 8'h05};                      run_frame();
    alu_lat_cfg = 2;
    frm = {8'hCC, 8'h12, 8'h34, 8'h00};        run_frame();
    check("alu_add_lsb", 32'(obs_tx[obs_tx.size() - 2]), 32'h46);
    check("alu_add_msb", 32'(obs_tx[obs_tx.size() - 1]), 32'h00);
    stall = 10;
    frm = {8'hDD, 8'h02};                      run_frame();
    frm = {8'h55};                             run_frame();
    alu_lat_cfg = 10;
    inject = 1;
    frm = {8'hCC, 8'hF0, 8'h20, 8'h01};        run_frame();
    rd_lat_cfg = 9;
    inject = 1;
    frm = {8'hBB, 8'h0E};                      run_frame();
    stall = 12;
    inject = 1;
    rd_lat_cfg = 1;
    frm = {8'hBB, 8'h01};                      run_frame();

    // Reset in the middle of a write frame
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge CLK_TB);
    check("midframe_busy", 32'(bus.BUSY), 32'd1);
    b_wr   = obs_wr.size();
    b_drop = obs_drop;
    @(posedge CLK_TB); #1;
    rst = 1'b1;
    @(posedge CLK_TB); #1;
    rst = 1'b0;
    @(negedge CLK_TB);
    check_idle("midreset");
    send_byte(8'h3C);
    repeat (4) @(negedge CLK_TB);
    check("midreset_drop", 32'(obs_drop - b_drop), 32'd1);
    check("midreset_nowr", 32'(obs_wr.size() - b_wr), 32'd0);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      t = int'($urandom_range(0, 4));
      rd_lat_cfg  = int'($urandom_range(1, 6));
      alu_lat_cfg = int'($urandom_range(1, 6));
      inject      = int'($urandom_range(0, 1));
      if (inject != 0) begin
        rd_lat_cfg  = int'($urandom_range(8, 12));
        alu_lat_cfg = int'($urandom_range(8, 12));
      end
      stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 15)) : 0;
      case (t)
        0: frm = {8'hAA, 8'($urandom), 8'($urandom)};
        1: frm = {8'hBB, 8'($urandom)};
        2: frm = {8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
        3: frm = {8'hDD, 8'($urandom)};
        default: begin
          bad = 8'($urandom);
          while (bad == 8'hAA || bad == 8'hBB || bad == 8'hCC || bad == 8'hDD) bad = 8'($urandom);
          frm = {bad};
        end
      endcase
      run_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : p_guard
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
